// File: rtl/stopwatch_display_if.sv
// Bundles the stopwatch counter value and the seven-segment display pins into one port.
interface stopwatch_display_if;
  logic [6:0] seconds;
  logic [6:0] seg;
  logic [3:0] an;
  logic       dp;
  logic       busy;

  modport master (output seconds, input seg, an, dp, busy);
  modport slave  (input seconds, output seg, an, dp, busy);
endinterface

// File: rtl/stopwatch_display.sv
// Binary seconds to mm:ss converter driving a 4-digit multiplexed common-anode display.
// Optional build macro LEADING_BLANK_EN blanks the minutes digits while they read zero.
module stopwatch_display #(
  parameter int REFRESH_DIV = 100_000
) (
  input  logic               clk,
  input  logic               reset,
  stopwatch_display_if.slave bus
);

  localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'(REFRESH_DIV - 1);

  typedef enum logic [1:0] {IDLE, SUB60, SUB10, LOAD} state_t;

  state_t        r_state;
  logic [6:0]    r_last_val;
  logic [6:0]    r_cap;
  logic [6:0]    r_work;
  logic [3:0]    r_m;
  logic [3:0]    r_t;
  logic [3:0]    r_min_o;
  logic [3:0]    r_sec_t;
  logic [3:0]    r_sec_o;
  logic          r_busy;

  logic [RW-1:0] r_refresh;
  logic [1:0]    r_idx;
  logic [6:0]    r_seg;
  logic [3:0]    r_an;
  logic          r_dp;

  logic [3:0]    w_digit;
  logic          w_blank;
  logic          w_dp;

  function automatic logic [6:0] seg_decode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b1111111;
    endcase
    return s;
  endfunction

  // Converter: the committed digits only change in LOAD, so the display never sees partial results.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= IDLE;
      r_last_val <= 7'd0;
      r_cap      <= 7'd0;
      r_work     <= 7'd0;
      r_m        <= 4'd0;
      r_t        <= 4'd0;
      r_min_o    <= 4'd0;
      r_sec_t    <= 4'd0;
      r_sec_o    <= 4'd0;
      r_busy     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.seconds != r_last_val) begin
            r_work  <= bus.seconds;
            r_cap   <= bus.seconds;
            r_m     <= 4'd0;
            r_t     <= 4'd0;
            r_state <= SUB60;
            r_busy  <= 1'b1;
          end
        end
        SUB60: begin
          if (r_work >= 7'd60) begin
            r_work <= r_work - 7'd60;
            r_m    <= r_m + 4'd1;
          end else begin
            r_state <= SUB10;
          end
        end
        SUB10: begin
          if (r_work >= 7'd10) begin
            r_work <= r_work - 7'd10;
            r_t    <= r_t + 4'd1;
          end else begin
            r_state <= LOAD;
          end
        end
        LOAD: begin
          r_min_o    <= r_m;
          r_sec_t    <= r_t;
          r_sec_o    <= r_work[3:0];
          r_last_val <= r_cap;
          r_state    <= IDLE;
          r_busy     <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_digit = 4'd0;
    w_blank = 1'b0;
    w_dp    = 1'b1;
    case (r_idx)
      2'd0:    w_digit = r_sec_o;
      2'd1:    w_digit = r_sec_t;
      2'd2:    begin
        w_digit = r_min_o;
        w_dp    = 1'b0;
      end
      default: w_digit = 4'd0;
    endcase
`ifdef LEADING_BLANK_EN
    // Minutes-tens is always zero, so it is always blanked; minutes blank only while zero.
    if (r_idx == 2'd3) begin
      w_blank = 1'b1;
    end else if (r_idx == 2'd2 && r_min_o == 4'd0) begin
      w_blank = 1'b1;
      w_dp    = 1'b1;
    end
`endif
  end

  // Scan: pins are registered from the current idx, so they trail idx by one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refresh <= '0;
      r_idx     <= 2'd0;
      r_seg     <= 7'b1111111;
      r_an      <= 4'b1111;
      r_dp      <= 1'b1;
    end else begin
      if (r_refresh == REF_LAST) begin
        r_refresh <= '0;
        r_idx     <= r_idx + 2'd1;
      end else begin
        r_refresh <= r_refresh + 1'b1;
      end
      r_an  <= ~(4'b0001 << r_idx);
      r_seg <= w_blank ? 7'b1111111 : seg_decode(w_digit);
      r_dp  <= w_dp;
    end
  end

  assign bus.seg  = r_seg;
  assign bus.an   = r_an;
  assign bus.dp   = r_dp;
  assign bus.busy = r_busy;

endmodule

// File: tb/tb_stopwatch_display.sv
// Directed bench for stopwatch_display with a latency/display scoreboard.
module tb_stopwatch_display;

  localparam int RD = 4;
  localparam logic [6:0] SEG_TAB [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                          7'b0000000, 7'b0010000};

  logic clk;
  logic reset;
  stopwatch_display_if bus ();

  stopwatch_display #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [11:0] exp_q [$];
  int          lat_q [$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] exp_out(input int v, input int idx);
    int mm;
    int d;
    logic [6:0] s;
    logic p;
    logic [3:0] a;
    mm = v / 60;
    case (idx)
      0:       d = v % 10;
      1:       d = (v % 60) / 10;
      2:       d = mm;
      default: d = 0;
    endcase
    s = SEG_TAB[d];
    p = (idx == 2) ? 1'b0 : 1'b1;
`ifdef LEADING_BLANK_EN
    if (idx == 3) s = 7'b1111111;
    if (idx == 2 && mm == 0) begin
      s = 7'b1111111;
      p = 1'b1;
    end
`endif
    a = 4'b0001 << idx;
    return {~a, s, p};
  endfunction

  function automatic int an2idx(input logic [3:0] a);
    case (a)
      4'b1101: return 1;
      4'b1011: return 2;
      4'b0111: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [11:0] obs_out();
    return {bus.an, bus.seg, bus.dp};
  endfunction

  task automatic set_sec(input int v);
    @(negedge clk);
    bus.seconds = 7'(v);
    lat_q.push_back(3 + v / 60 + (v % 60) / 10);
  endtask

  // One full frame starting at the entry into the rightmost-digit slot.
  task automatic check_frame(input int v, input string tag);
    logic [3:0] prev;
    logic [11:0] e;
    bit found;
    for (int i = 0; i < 4; i++)
      for (int k = 0; k < RD; k++)
        exp_q.push_back(exp_out(v, i));
    found = 1'b0;
    prev = bus.an;
    for (int c = 0; c < 40 && !found; c++) begin
      @(negedge clk);
      if (bus.an == 4'b1110 && prev != 4'b1110) found = 1'b1;
      else prev = bus.an;
    end
    chk({tag, "_align"}, 32'(found), 32'd1);
    if (found) begin
      for (int k = 0; k < 4 * RD; k++) begin
        if (k > 0) @(negedge clk);
        e = exp_q.pop_front();
        chk(tag, 32'(obs_out()), 32'(e));
      end
    end else begin
      exp_q.delete();
    end
  endtask

  // Measures one busy run; if prev_v >= 0 the display must hold prev_v throughout.
  task automatic wait_conv(input int prev_v, input string tag, output int elapsed);
    bit got;
    int len;
    int e;
    elapsed = 0;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      elapsed++;
      if (bus.busy) got = 1'b1;
    end
    chk({tag, "_start"}, 32'(got), 32'd1);
    len = 0;
    while (got && bus.busy && len < 40) begin
      if (prev_v >= 0) chk({tag, "_hold"}, 32'(obs_out()), 32'(exp_out(prev_v, an2idx(bus.an))));
      len++;
      @(negedge clk);
      elapsed++;
    end
    e = lat_q.pop_front();
    chk({tag, "_busy_len"}, 32'(len), 32'(e));
  endtask

  initial begin
    int el;
    int run;
    int gap;
    int e;
    bit got;
    reset = 1'b0;
    bus.seconds = 7'd0;
    repeat (2) @(negedge clk);
    chk("rst_out", 32'({obs_out(), bus.busy}), 32'({4'b1111, 7'b1111111, 1'b1, 1'b0}));
    reset = 1'b1;
    @(negedge clk);
    chk("first_cycle", 32'({obs_out(), bus.busy}), 32'({4'b1110, 7'b1000000, 1'b1, 1'b0}));
    check_frame(0, "frame_0");

    set_sec(119);
    wait_conv(0, "conv_119", el);
    check_frame(119, "frame_119");

    set_sec(127);
    wait_conv(119, "conv_127", el);
    check_frame(127, "frame_127");
    set_sec(0);
    wait_conv(127, "conv_wrap0", el);
    check_frame(0, "frame_wrap0");

    // Change to 60 while the 59 conversion is running.
    set_sec(59);
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.busy) got = 1'b1;
    end
    chk("mid_start", 32'(got), 32'd1);
    bus.seconds = 7'd60;
    lat_q.push_back(4);
    run = 0;
    while (bus.busy && run < 40) begin
      run++;
      @(negedge clk);
    end
    e = lat_q.pop_front();
    chk("mid_run1", 32'(run), 32'(e));
    gap = 0;
    while (!bus.busy && gap < 10) begin
      gap++;
      @(negedge clk);
    end
    chk("mid_gap", 32'(gap), 32'd1);
    run = 0;
    while (bus.busy && run < 40) begin
      chk("mid_show59", 32'(obs_out()), 32'(exp_out(59, an2idx(bus.an))));
      run++;
      @(negedge clk);
    end
    e = lat_q.pop_front();
    chk("mid_run2", 32'(run), 32'(e));
    check_frame(60, "frame_60");

    // Reset while converting 75, sampled in SUB10.
    @(negedge clk);
    bus.seconds = 7'd75;
    got = 1'b0;
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.busy) got = 1'b1;
    end
    chk("r75_start", 32'(got), 32'd1);
    repeat (2) @(negedge clk);
    chk("r75_busy_sub10", 32'(bus.busy), 32'd1);
    reset = 1'b0;
    #1;
    chk("r75_async", 32'({obs_out(), bus.busy}), 32'({4'b1111, 7'b1111111, 1'b1, 1'b0}));
    @(negedge clk);
    chk("r75_held", 32'({obs_out(), bus.busy}), 32'({4'b1111, 7'b1111111, 1'b1, 1'b0}));
    reset = 1'b1;
    lat_q.push_back(5);
    wait_conv(-1, "r75_conv", el);
    chk("r75_within10", 32'(el <= 10), 32'd1);
    check_frame(75, "frame_75");

    set_sec(45);
    wait_conv(75, "conv_45", el);
    check_frame(45, "frame_45");
    set_sec(65);
    wait_conv(45, "conv_65", el);
    check_frame(65, "frame_65");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/stopwatch_display.md
# stopwatch_display

Downstream display stage for the smartwatch stopwatch counter. Takes the counter's 7-bit binary seconds value (0–127) and converts it to minutes:seconds using a sequential subtract-based converter. Drives a 4-digit, time-multiplexed, common-anode seven-segment display with a colon point. Sits between the stopwatch counter and the board's segment/anode pins.

## Interface
Parameters:
- `REFRESH_DIV`, default 100_000: clock cycles each digit stays enabled. Legal range ≥2.

Ports:
- `clk`  in  1  system clock
- `reset`  in  1  reset; one clock; reset is asynchronous and active-low
- `seconds`  in  7  binary elapsed seconds from the stopwatch counter; unsigned; may change on any cycle
- `seg`  out  7  segment drive, active-low
  - bit order {g,f,e,d,c,b,a}
  - digit codes: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
  - blank=1111111
- `an`  out  4  digit enables, active-low; bit0 = rightmost digit
- `dp`  out  1  decimal point, active-low; used as the mm:ss separator
- `busy`  out  1  high while a conversion is in progress

## Operation
- Internal state:
  - `last_val` (7b): last converted input
  - `work` (7b)
  - working digit counters `m`, `t`
  - committed display digits `min_o`, `sec_t`, `sec_o` (4b each)
  - minutes-tens digit: always 0, because 127 s is at most 2 min
- Converter FSM states: IDLE, SUB60, SUB10, LOAD.
  - IDLE: if `seconds != last_val`, capture `work<=seconds`, `m<=0`, `t<=0`, and go to SUB60. Otherwise stay in IDLE.
  - SUB60: if `work>=60`, then `work<=work-60` and `m<=m+1`. Otherwise go to SUB10.
  - SUB10: if `work>=10`, then `work<=work-10` and `t<=t+1`. Otherwise go to LOAD.
  - LOAD: commit `min_o<=m`, `sec_t<=t`, `sec_o<=work[3:0]`, and `last_val<=` the captured value, all atomically in one cycle. Return to IDLE.
- `busy` = 1 in SUB60, SUB10 and LOAD; 0 in IDLE.
- Input changes during a conversion are ignored for that conversion. On return to IDLE, the mismatch with `last_val` triggers a reconversion, so the display always converges to the latest value.
- Committed digits never show partial results.
- Scan logic:
  - `refresh` counter runs 0..REFRESH_DIV-1.
  - At the terminal count it wraps to 0 and the digit index `idx` (2b) advances 0→1→2→3→0.
  - Digit mapping: idx0 = `sec_o`, idx1 = `sec_t`, idx2 = `min_o`, idx3 = minutes-tens (0).
  - `an` = ~(1<<idx).
  - `dp` = 0 only when idx==2; 1 otherwise.

## Timing
- Reset values (asserted or async entry):
  - FSM = IDLE, `last_val`=0, all digits=0
  - `refresh`=0, `idx`=0
  - `an`=1111, `seg`=1111111, `dp`=1, `busy`=0
- `seg`, `an`, `dp` are registered: they reflect `idx` and the committed digits with one-cycle lag.
  - First cycle after reset release: `an`=1110, `seg`=1000000.
- Conversion latency, from the IDLE edge that captures a new value to the LOAD commit edge: 3 + n60 + n10 cycles.
  - n60 and n10 are the subtraction counts.
  - Minimum is 3 (value 0); maximum is 9 (value 119).
  - Updated digits appear on `seg` the cycle after the commit, once `idx` selects that digit.
- Each digit stays enabled for exactly REFRESH_DIV cycles; a full frame is 4·REFRESH_DIV cycles.
- Input wrap 127→0 is a normal change: it converts to 00:00.
- Reset asserted mid-conversion aborts the conversion immediately.
  - After release, with `seconds` nonzero, a conversion starts on the first edge.

## Configuration
- `LEADING_BLANK_EN`: zero blanking on the minutes digits.
- Defined:
  - idx3 is always blank (`seg`=1111111).
  - idx2 is blank and `dp` stays 1 while the committed minutes = 0.
  - `an` still scans all four digits.
- Undefined: all four digits always show numerals and `dp` is lit on every idx2 slot.

## Test plan
- Reset, then hold `seconds`=0 with REFRESH_DIV=4:
  - `an` cycles 1110→1101→1011→0111, 4 cycles each.
  - `seg`=1000000 on all digits; `dp`=0 only when `an`=1011.
- Step `seconds` 0→119: `busy` high for 9 cycles, then digits read min=1, sec_t=5, sec_o=9.
  - `seg` is 1111001 / 0010010 / 0010000 when the respective digit is enabled.
- `seconds`=127, then 0 (wrap): display shows 02:07, then 00:00; no intermediate digit values appear.
- Change `seconds` 59→60 on the second cycle of the 59 conversion:
  - the first commit shows 00:59;
  - a second conversion starts immediately and shows 01:00.
- Assert `reset` low during SUB10 of a conversion of 75: outputs take their reset values asynchronously.
  - After release with `seconds`=75, the display shows 01:15 within 10 cycles.
- With `LEADING_BLANK_EN` defined and `seconds`=45: idx2 and idx3 show 1111111 and `dp` stays 1.
  - `seconds`=65 then lights idx2 with 1111001 and `dp`=0.
